truth_table_capture: RTL and testbench
======================================

# truth_table_capture

Sequential response collector for single-output, 3-input combinational functions. It drives all eight input vectors onto the function under test in ascending order and samples the output after a configurable settle time. It then assembles the 8-bit truth table and optionally compares it against an expected table. It sits opposite the function block: the function consumes a/b/c, and this block produces a/b/c and consumes s.

## Interface
Parameters:
- SETTLE, default 1: wait cycles between driving a vector and sampling s; legal range 0..15.
- EXPECTED, default 8'hF4: golden table, bit index {a,b,c}. The default encodes s = a | (b & ~c).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  sweep request; sampled only in IDLE.
- a  output  1  vector MSB to the function under test.
- b  output  1  vector middle bit.
- c  output  1  vector LSB.
- s  input  1  function output, sampled by this block.
- busy  output  1  high from the cycle after start is accepted through the FINISH cycle.
- done  output  1  one-cycle pulse in FINISH.
- table_out  output  8  captured truth table, bit i = s for {a,b,c} = i.
- pass  output  1  table_out == EXPECTED (checker builds only).
- mism_mask  output  8  table_out ^ EXPECTED (checker builds only).

## Operation
- States are IDLE, DRIVE and FINISH. A 3-bit idx counter and a 4-bit wait counter run the sweep.
- Reset values: a = b = c = 0, busy = 0, done = 0, table_out = 8'h00, pass = 0, mism_mask = 8'h00, state = IDLE, idx = 0, wait = 0.
- IDLE:
  - With start = 1: go to DRIVE, idx <= 0, wait <= SETTLE, table_out <= 0, pass <= 0, mism_mask <= 0.
  - Otherwise: hold all outputs, including the previous results.
- DRIVE:
  - {a,b,c} = idx, registered. busy = 1.
  - If wait != 0: decrement wait.
  - If wait == 0: table_out[idx] <= s.
    - If idx == 7: go to FINISH.
    - Otherwise: idx <= idx + 1, wait <= SETTLE.
- FINISH:
  - done = 1 and busy = 1. pass and mism_mask update from the complete table.
  - {a,b,c} returns to 0. Next state is IDLE.
- start is ignored in DRIVE and FINISH; requests are not queued.
- idx does not wrap during a sweep. The transition at idx == 7 is the only exit from DRIVE.
- s is captured as-is. An X or Z on s propagates into table_out.

## Timing
- The first vector (000) appears on a/b/c in the cycle after start is accepted.
- Each vector is held for SETTLE+1 cycles. s is sampled at the edge that ends the vector's last cycle.
- The sweep lasts 8*(SETTLE+1) cycles. done is asserted in the next cycle.
  - Start-accept edge to done high: 8*(SETTLE+1)+1 cycles.
- With SETTLE = 0, s is sampled one edge after the vector is registered. This requires a purely combinational path from a/b/c to s.
- Earliest restart: start in the cycle after FINISH, since the block is back in IDLE.
- Reset asserted mid-sweep returns all outputs to reset values immediately, without waiting for clk. The partial table is discarded.

## Configuration
- TT_CHECK_EN defined:
  - The comparator against EXPECTED is built.
  - pass and mism_mask update in FINISH and hold until the next accepted start.
- TT_CHECK_EN undefined:
  - No comparator is built.
  - pass and mism_mask are tied to 0 permanently.
  - table_out, done and busy behave identically in both builds.

## Test plan
- Reset: assert rst_n = 0 mid-cycle -> all outputs take their reset values asynchronously, before the next clk edge.
- Golden sweep, SETTLE = 1, function s = a | (b & ~c), TT_CHECK_EN defined -> vectors 000..111 held 2 cycles each; done 17 cycles after start; table_out = 8'hF4, pass = 1, mism_mask = 8'h00.
- Faulty function s = a, SETTLE = 1 -> table_out = 8'hF0, pass = 0, mism_mask = 8'h04; done pulse lasts exactly 1 cycle.
- start pulsed during DRIVE and during FINISH -> no restart; single done; idx sequence 0..7 uninterrupted.
- Reset mid-sweep (idx = 4), then a new start with SETTLE = 0 -> clean sweep of 8 cycles, done at cycle 9, table_out = 8'hF4.
- Build without TT_CHECK_EN, golden sweep -> table_out = 8'hF4, pass = 0, mism_mask = 8'h00 throughout.

Source files
------------

// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps a/b/c through 000..111, samples s after SETTLE cycles, assembles the truth table.
// Define TT_CHECK_EN to build the comparator that drives pass/mism_mask against EXPECTED.
module truth_table_capture #(
  parameter int SETTLE = 1,
  parameter logic [7:0] EXPECTED = 8'hF4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       s,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass,
  output logic [7:0] mism_mask
);
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, FINISH = 2'd2;
  localparam logic [3:0] SET = 4'(SETTLE);
  logic [1:0] state;
  logic [2:0] idx, vec;
  logic [3:0] wait_cnt;
  logic [7:0] tbl_next;
  always_comb begin
    tbl_next = table_out;
    tbl_next[idx] = s;
  end
  assign {a, b, c} = vec;
  assign busy = state != IDLE;
  assign done = state == FINISH;
`ifndef TT_CHECK_EN
  assign pass = 1'b0;
  assign mism_mask = 8'h00;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= 3'd0;
      wait_cnt <= 4'd0;
      vec <= 3'd0;
      table_out <= 8'h00;
`ifdef TT_CHECK_EN
      pass <= 1'b0;
      mism_mask <= 8'h00;
`endif
    end else
      case (state)
        IDLE:
          if (start) begin
            state <= DRIVE;
            idx <= 3'd0;
            vec <= 3'd0;
            wait_cnt <= SET;
            table_out <= 8'h00;
`ifdef TT_CHECK_EN
            pass <= 1'b0;
            mism_mask <= 8'h00;
`endif
          end
        DRIVE:
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          else begin
            table_out <= tbl_next;
            if (idx == 3'd7) begin
              state <= FINISH;
              vec <= 3'd0;
`ifdef TT_CHECK_EN
              // judged on the completed table so the verdict is valid alongside done
              pass <= tbl_next == EXPECTED;
              mism_mask <= tbl_next ^ EXPECTED;
`endif
            end else begin
              idx <= idx + 3'd1;
              vec <= idx + 3'd1;
              wait_cnt <= SET;
            end
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_truth_table_capture.sv
// tb_truth_table_capture: table-driven and randomized sweeps on SETTLE=0 and SETTLE=1 instances.
module tb_truth_table_capture;
`ifdef TT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [7:0] GOLD = 8'hF4;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [1:0] start_v = 2'b00, a_v, b_v, c_v, s_v, busy_v, done_v, pass_v;
  logic [7:0] tbl_v [2];
  logic [7:0] mask_v [2];
  logic [7:0] ftab [2];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  // the function under test: a lookup of whatever table the bench loaded
  assign s_v[0] = ftab[0][{a_v[0], b_v[0], c_v[0]}];
  assign s_v[1] = ftab[1][{a_v[1], b_v[1], c_v[1]}];
  truth_table_capture #(.SETTLE(0), .EXPECTED(GOLD)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .c(c_v[0]),
    .s(s_v[0]), .busy(busy_v[0]), .done(done_v[0]), .table_out(tbl_v[0]),
    .pass(pass_v[0]), .mism_mask(mask_v[0]));
  truth_table_capture #(.SETTLE(1), .EXPECTED(GOLD)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .c(c_v[1]),
    .s(s_v[1]), .busy(busy_v[1]), .done(done_v[1]), .table_out(tbl_v[1]),
    .pass(pass_v[1]), .mism_mask(mask_v[1]));
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_idle_zero(input int k);
    chk("rst_abc", {5'd0, a_v[k], b_v[k], c_v[k]}, 8'h00);
    chk("rst_busy_done", {6'd0, busy_v[k], done_v[k]}, 8'h00);
    chk("rst_table", tbl_v[k], 8'h00);
    chk("rst_pass", {7'd0, pass_v[k]}, 8'h00);
    chk("rst_mask", mask_v[k], 8'h00);
  endtask
  // One sweep: cycle 0 asserts start; model expects vector (t-1)/(S+1) in cycle t, done only in cycle T+1.
  task automatic sweep(input int k, input logic [7:0] f, input bit poke,
                       input logic [7:0] exp_tbl, input bit exp_pass, input logic [7:0] exp_mask);
    int st, tl;
    st = k;
    tl = 8 * (st + 1);
    ftab[k] = f;
    @(negedge clk);
    start_v[k] = 1'b1;
    for (int t = 1; t <= tl + 1; t++) begin
      @(negedge clk);
      start_v[k] = poke && (t == 3 || t == tl + 1);
      chk("vector", {5'd0, a_v[k], b_v[k], c_v[k]}, (t <= tl) ? 8'((t - 1) / (st + 1)) : 8'h00);
      chk("busy", {7'd0, busy_v[k]}, 8'h01);
      chk("done", {7'd0, done_v[k]}, {7'd0, t == tl + 1});
    end
    chk("table", tbl_v[k], exp_tbl);
    chk("pass", {7'd0, pass_v[k]}, {7'd0, exp_pass});
    chk("mask", mask_v[k], exp_mask);
    @(negedge clk);
    start_v[k] = 1'b0;
    chk("idle_busy_done", {6'd0, busy_v[k], done_v[k]}, 8'h00);
    chk("idle_abc", {5'd0, a_v[k], b_v[k], c_v[k]}, 8'h00);
    chk("hold_table", tbl_v[k], exp_tbl);
    chk("hold_pass", {7'd0, pass_v[k]}, {7'd0, exp_pass});
    chk("hold_mask", mask_v[k], exp_mask);
  endtask
  typedef struct {
    int k;
    logic [7:0] f;
    bit poke;
    logic [7:0] exp_tbl;
    bit exp_pass;
    logic [7:0] exp_mask;
  } vec_t;
  vec_t vecs [5];
  initial begin
    ftab[0] = GOLD;
    ftab[1] = GOLD;
    vecs[0] = '{1, 8'hF4, 1'b0, 8'hF4, CHK, 8'h00};
    vecs[1] = '{1, 8'hF0, 1'b0, 8'hF0, 1'b0, CHK ? 8'h04 : 8'h00};
    vecs[2] = '{1, 8'hF4, 1'b1, 8'hF4, CHK, 8'h00};
    vecs[3] = '{0, 8'hF4, 1'b0, 8'hF4, CHK, 8'h00};
    vecs[4] = '{0, 8'h5A, 1'b1, 8'h5A, 1'b0, CHK ? 8'hAE : 8'h00};
    #2 rst_n = 1'b0;
    #1;
    chk_idle_zero(0);
    chk_idle_zero(1);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) sweep(vecs[i].k, vecs[i].f, vecs[i].poke, vecs[i].exp_tbl, vecs[i].exp_pass, vecs[i].exp_mask);
    for (int i = 0; i < 8; i++) begin
      int k;
      logic [7:0] f;
      k = int'($urandom_range(0, 1));
      f = 8'($urandom);
      sweep(k, f, 1'($urandom), f, CHK && f == GOLD, CHK ? f ^ GOLD : 8'h00);
    end
    // asynchronous reset while SETTLE=1 sweep is on vector 4, then a clean SETTLE=0 sweep
    ftab[1] = GOLD;
    @(negedge clk);
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    for (int t = 2; t <= 9; t++) @(negedge clk);
    chk("pre_reset_vector", {5'd0, a_v[1], b_v[1], c_v[1]}, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_zero(1);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, GOLD, 1'b0, GOLD, CHK, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
